// File: rtl/const_block_server.sv
// Streams the n_squared / k constant blocks from one shared single-port BRAM
// to several valid/ready consumers, issuing at most one read per cycle.
module const_block_server #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128,
  parameter int NUM_STREAMS   = 4,
  parameter int READ_LATENCY  = 2
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [NUM_STREAMS-1:0]               restart_in,
  input  logic [NUM_STREAMS-1:0]               ready_in,
  output logic [NUM_STREAMS-1:0]               valid_out,
  output logic [NUM_STREAMS-1:0]               last_out,
  output logic [NUM_STREAMS*REGISTER_SIZE-1:0] data_out,
  output logic [$clog2(2*NUM_BLOCKS)-1:0]      bram_addr_out,
  input  logic [REGISTER_SIZE-1:0]             bram_data_in
);

  localparam int IDX_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int ADDR_W = $clog2(2*NUM_BLOCKS);
  localparam int SID_W  = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

  logic [IDX_W-1:0]         r_idx  [NUM_STREAMS];
  logic [REGISTER_SIZE-1:0] r_data [NUM_STREAMS];
  logic [NUM_STREAMS-1:0]   r_vld;
  logic [NUM_STREAMS-1:0]   r_pend;
  logic [NUM_STREAMS-1:0]   r_last;
  logic [SID_W-1:0]         r_ptr;
  logic [ADDR_W-1:0]        r_addr;

  logic [READ_LATENCY-1:0]  r_pvld;
  logic [READ_LATENCY-1:0]  r_plast;
  logic [READ_LATENCY-1:0]  r_pkill;
  logic [SID_W-1:0]         r_pid [READ_LATENCY];

  logic [NUM_STREAMS-1:0]   w_elig;
  logic                     w_grant;
  logic [SID_W-1:0]         w_gid;
  logic [IDX_W-1:0]         w_gidx;
  logic [ADDR_W-1:0]        w_addr;
  logic                     w_ret;
  logic                     w_retKill;
  logic                     w_retLast;
  logic [SID_W-1:0]         w_retId;

  function automatic logic [SID_W-1:0] nextId(input logic [SID_W-1:0] base, input int k);
    return SID_W'((int'(base) + k) % NUM_STREAMS);
  endfunction

  // Round-robin search starting just after the last granted stream.
  always_comb begin
    w_elig  = ~r_vld & ~r_pend & ~restart_in;
    w_grant = 1'b0;
    w_gid   = '0;
    for (int k = 1; k <= NUM_STREAMS; k++) begin
      if (!w_grant && w_elig[nextId(r_ptr, k)]) begin
        w_grant = 1'b1;
        w_gid   = nextId(r_ptr, k);
      end
    end
    if (rst_in) w_grant = 1'b0;
    w_gidx = r_idx[w_gid];
    w_addr = ADDR_W'(w_gid[0] ? NUM_BLOCKS : 0) + ADDR_W'(w_gidx);
  end

  assign w_ret     = r_pvld[READ_LATENCY-1];
  assign w_retKill = r_pkill[READ_LATENCY-1];
  assign w_retLast = r_plast[READ_LATENCY-1];
  assign w_retId   = r_pid[READ_LATENCY-1];

  // In-flight reads; a restart marks every entry of that stream as killed.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pvld  <= '0;
      r_plast <= '0;
      r_pkill <= '0;
      for (int j = 0; j < READ_LATENCY; j++) r_pid[j] <= '0;
    end else begin
      r_pvld[0]  <= w_grant;
      r_pid[0]   <= w_gid;
      r_plast[0] <= (w_gidx == IDX_W'(NUM_BLOCKS-1));
      r_pkill[0] <= 1'b0;
      for (int j = 1; j < READ_LATENCY; j++) begin
        r_pvld[j]  <= r_pvld[j-1];
        r_pid[j]   <= r_pid[j-1];
        r_plast[j] <= r_plast[j-1];
        r_pkill[j] <= r_pkill[j-1] | restart_in[r_pid[j-1]];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_vld  <= '0;
      r_pend <= '0;
      r_last <= '0;
      r_ptr  <= '0;
      r_addr <= '0;
      for (int s = 0; s < NUM_STREAMS; s++) begin
        r_idx[s]  <= '0;
        r_data[s] <= '0;
      end
    end else begin
      if (w_grant) begin
        r_ptr  <= w_gid;
        r_addr <= w_addr;
      end
      for (int s = 0; s < NUM_STREAMS; s++) begin
        if (w_ret && w_retId == SID_W'(s)) r_pend[s] <= 1'b0;
        else if (w_grant && w_gid == SID_W'(s)) r_pend[s] <= 1'b1;
        // Restart overrides retire and consume; killed data is simply dropped.
        if (restart_in[s]) begin
          r_idx[s]  <= '0;
          r_vld[s]  <= 1'b0;
          r_last[s] <= 1'b0;
        end else begin
          if (w_grant && w_gid == SID_W'(s))
            r_idx[s] <= (r_idx[s] == IDX_W'(NUM_BLOCKS-1)) ? '0 : r_idx[s] + 1'b1;
          if (w_ret && w_retId == SID_W'(s) && !w_retKill) begin
            r_data[s] <= bram_data_in;
            r_vld[s]  <= 1'b1;
            r_last[s] <= w_retLast;
          end else if (ready_in[s] && r_vld[s]) begin
            r_vld[s]  <= 1'b0;
            r_last[s] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    data_out = '0;
    for (int s = 0; s < NUM_STREAMS; s++)
      data_out[s*REGISTER_SIZE +: REGISTER_SIZE] = r_data[s];
  end

  assign valid_out     = r_vld;
  assign last_out      = r_last;
  assign bram_addr_out = w_grant ? w_addr : r_addr;

endmodule

// File: tb/tb_const_block_server.sv
// Self-checking bench for const_block_server: a BRAM whose word(a)=a, a
// per-stream expected-block scoreboard, and directed literal scenarios.
module tb_const_block_server;

  localparam int RS = 32;
  localparam int NB = 128;
  localparam int NS = 4;
  localparam int RL = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS-1:0]   restart;
  logic [NS-1:0]   ready;
  logic [NS-1:0]   validOut;
  logic [NS-1:0]   lastOut;
  logic [NS*RS-1:0] dataOut;
  logic [7:0]      bramAddr;
  logic [RS-1:0]   bramData;
  logic [7:0]      bramPipe [RL] = '{default: 8'd0};

  int testsRun = 0;
  int testsFailed = 0;

  int            expIdx [NS];
  bit            newBlk [NS];
  bit            restartSeen [NS];
  logic [RS-1:0] held [NS];
  int            deliveries [NS] = '{default: 0};
  logic [RS-1:0] cmpData;
  bit            consume;

  always #5 clk = ~clk;

  const_block_server #(
    .REGISTER_SIZE(RS), .NUM_BLOCKS(NB), .NUM_STREAMS(NS), .READ_LATENCY(RL)
  ) dut (
    .clk_in(clk), .rst_in(rst), .restart_in(restart), .ready_in(ready),
    .valid_out(validOut), .last_out(lastOut), .data_out(dataOut),
    .bram_addr_out(bramAddr), .bram_data_in(bramData)
  );

  // Registered BRAM: address in one cycle, data READ_LATENCY cycles later.
  always @(posedge clk) begin
    bramPipe[0] <= bramAddr;
    for (int j = 1; j < RL; j++) bramPipe[j] <= bramPipe[j-1];
  end
  assign bramData = RS'(bramPipe[RL-1]);

  function automatic logic [RS-1:0] word(input int s, input int idx);
    return RS'((s % 2) * NB + idx);
  endfunction

  task automatic checkOutput(input string name, input logic [RS-1:0] actual, input logic [RS-1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic [NS-1:0] restartV,
                               input logic [NS-1:0] readyV, input int cycles);
    rst = rstV;
    restart = restartV;
    ready = readyV;
    step(cycles);
  endtask

  // Scoreboard: each stream must present its constant's blocks in order,
  // hold data while not consumed, and drop everything after a restart.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("resetValid", RS'(validOut), '0);
      checkOutput("resetLast", RS'(lastOut), '0);
      checkOutput("resetData", RS'(|dataOut), '0);
      checkOutput("resetAddr", RS'(bramAddr), '0);
      for (int s = 0; s < NS; s++) begin
        expIdx[s] = 0;
        newBlk[s] = 1'b1;
        restartSeen[s] = 1'b0;
      end
    end else begin
      for (int s = 0; s < NS; s++) begin
        cmpData = dataOut[s*RS +: RS];
        if (restartSeen[s])
          checkOutput($sformatf("restartFlush[%0d]", s), RS'(validOut[s]), '0);
        if (validOut[s]) begin
          if (newBlk[s]) begin
            checkOutput($sformatf("blockData[%0d]", s), cmpData, word(s, expIdx[s]));
            checkOutput($sformatf("blockLast[%0d]", s), RS'(lastOut[s]), RS'(expIdx[s] == NB-1));
            held[s] = cmpData;
            deliveries[s]++;
          end else begin
            checkOutput($sformatf("heldData[%0d]", s), cmpData, held[s]);
          end
        end
        consume = validOut[s] && ready[s] && !restart[s];
        if (restart[s]) expIdx[s] = 0;
        else if (consume) expIdx[s] = (expIdx[s] + 1) % NB;
        newBlk[s] = !validOut[s] || consume || restart[s];
        restartSeen[s] = restart[s];
      end
    end
  end

  int  addrHigh;
  int  d0, d2;
  bit  found;

  initial begin
    rst = 1'b1;
    restart = '0;
    ready = '0;
    step(3);
    checkOutput("resetValidLit", RS'(validOut), '0);
    checkOutput("resetAddrLit", RS'(bramAddr), '0);

    // Only stream 0 eligible: first valid three cycles after release.
    applyStimulus(1'b0, 4'b1110, 4'b1111, 2);
    checkOutput("lat0Early", RS'(validOut[0]), '0);
    step(1);
    checkOutput("lat0Valid", RS'(validOut[0]), 32'd1);
    checkOutput("lat0Data", dataOut[31:0], 32'd0);
    step(20);

    // Only stream 2 eligible: one block every 4 cycles, addresses 0,1,2,3.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 2);
    rst = 1'b0;
    restart = 4'b1011;
    ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("s2Addr%0d", k), RS'(bramAddr), RS'(k));
      step(2);
      checkOutput($sformatf("s2Gap%0d", k), RS'(validOut[2]), '0);
      step(1);
      checkOutput($sformatf("s2Valid%0d", k), RS'(validOut[2]), 32'd1);
      checkOutput($sformatf("s2Data%0d", k), dataOut[95:64], RS'(k));
      step(1);
    end

    // All four eligible: grants go to streams 1,2,3,0.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 2);
    rst = 1'b0;
    step(3);
    checkOutput("rrOrder1", RS'(validOut), 32'h2);
    step(1);
    checkOutput("rrOrder2", RS'(validOut), 32'h6);
    step(1);
    checkOutput("rrOrder3", RS'(validOut), 32'he);
    step(1);
    checkOutput("rrOrder0", RS'(validOut), 32'hf);

    // Stream 1 stalled, stream 3 parked: no k-address reads may appear.
    ready = 4'b1101;
    restart = 4'b1000;
    addrHigh = 0;
    d0 = deliveries[0];
    d2 = deliveries[2];
    for (int i = 0; i < 100; i++) begin
      if (bramAddr >= 8'd128) addrHigh++;
      step(1);
    end
    checkOutput("stallNoRead", RS'(addrHigh), '0);
    checkOutput("stallValid", RS'(validOut[1]), 32'd1);
    checkOutput("stallData", dataOut[63:32], 32'd128);
    checkOutput("stallProgress0", RS'((deliveries[0] - d0) >= 20), 32'd1);
    checkOutput("stallProgress2", RS'((deliveries[2] - d2) >= 20), 32'd1);
    applyStimulus(1'b0, 4'b0000, 4'b1111, 40);

    // Restart stream 3 right after it consumed block 49.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (validOut[3] && dataOut[127:96] == 32'd177) found = 1'b1;
      else step(1);
    end
    checkOutput("s3Reach49", RS'(found), 32'd1);
    step(2);
    restart = 4'b1000;
    step(1);
    restart = 4'b0000;
    checkOutput("s3Dropped", RS'(validOut[3]), '0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (validOut[3]) found = 1'b1;
      else step(1);
    end
    checkOutput("s3Refetch", RS'(found), 32'd1);
    checkOutput("s3Block0", dataOut[127:96], 32'd128);

    // Stream 1 reaches its last block, then wraps.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (validOut[1] && lastOut[1]) found = 1'b1;
      else step(1);
    end
    checkOutput("s1Last", RS'(found), 32'd1);
    checkOutput("s1LastData", dataOut[63:32], 32'd255);
    step(8);

    // Asynchronous reset mid-burst.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midRstValid", RS'(validOut), '0);
    checkOutput("midRstLast", RS'(lastOut), '0);
    checkOutput("midRstData", RS'(|dataOut), '0);
    checkOutput("midRstAddr", RS'(bramAddr), '0);
    step(2);
    applyStimulus(1'b0, 4'b1110, 4'b1111, 2);
    checkOutput("postRstEarly", RS'(validOut[0]), '0);
    step(1);
    checkOutput("postRstValid", RS'(validOut[0]), 32'd1);
    checkOutput("postRstData", dataOut[31:0], 32'd0);
    applyStimulus(1'b0, 4'b0000, 4'b1111, 30);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
